// File: rtl/wb_arbiter_2to1.sv
// wb_arbiter_2to1
//   Shares one Wishbone bus between the instruction-fetch controller (m0) and
//   the data controller (m1). Once a controller is granted, it keeps the bus
//   for its whole CYC. A watchdog aborts a granted transfer with ERR when the
//   slave stops responding.
// Parameters
//   ROUND_ROBIN    : 1 = alternate owners on contention, 0 = m1 always wins
//   TIMEOUT_CYCLES : granted stb cycles without ack/err before a forced ERR (0 = off)
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   m0_wb_* / m1_wb_*       controller-side Wishbone ports (the arbiter is their peripheral)
//   s_wb_*                  downstream Wishbone port (the arbiter is its controller)
//   o_grant                 registered one-hot owner {m1,m0}, 2'b00 when idle
//   o_timeout               one-cycle pulse while an abort is in progress
module wb_arbiter_2to1 #(
  parameter bit ROUND_ROBIN    = 1'b1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // controller 0 (instruction fetch)
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_we_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_w_i,
  output logic [31:0] m0_wb_dat_r_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  output logic        m0_wb_stall_o,
  // controller 1 (data load/store)
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_we_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_w_i,
  output logic [31:0] m1_wb_dat_r_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic        m1_wb_stall_o,
  // shared downstream bus
  output logic        s_wb_cyc_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_we_o,
  output logic [3:0]  s_wb_sel_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_w_o,
  input  logic [31:0] s_wb_dat_r_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_err_i,
  input  logic        s_wb_stall_i,
  // status
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_e;

  localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [16:0] TO_L    = 17'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;     // 0: m0 owned last, 1: m1 owned last
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  logic        pick1, own_cyc, own_stb;
  logic [16:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b0;
      cnt_q   <= 16'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // next state, grant, watchdog
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    pick1   = 1'b0;
    own_cyc = (state_q == OWN1) ? m1_wb_cyc_i : m0_wb_cyc_i;
    own_stb = own_cyc & ((state_q == OWN1) ? m1_wb_stb_i : m0_wb_stb_i);
    case (state_q)
      IDLE: begin
        grant_d = 2'b00;
        cnt_d   = 16'd0;
        if (m0_wb_cyc_i && m1_wb_cyc_i) pick1 = ROUND_ROBIN ? ~last_q : 1'b1;
        else                            pick1 = m1_wb_cyc_i;
        if (m0_wb_cyc_i || m1_wb_cyc_i) begin
          state_d = pick1 ? OWN1 : OWN0;
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
        end
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          // owner released (or abandoned) the cycle
          state_d = IDLE;
          grant_d = 2'b00;
          cnt_d   = 16'd0;
        end else if (s_wb_ack_i || s_wb_err_i) begin
          cnt_d = 16'd0;
        end else if (own_stb) begin
          cnt_d = cnt_q + 16'd1;
          // abort on the edge where the count reaches the limit
          if (WDOG_EN && (cnt_inc == TO_L)) begin
            state_d = ABORT;
            tmo_d   = 1'b1;
          end
        end
      end
      default: begin  // ABORT: grant_q still names the victim for this cycle
        state_d = IDLE;
        grant_d = 2'b00;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // bus routing
  always_comb begin
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    s_wb_sel_o    = 4'h0;
    s_wb_adr_o    = 32'h0;
    s_wb_dat_w_o  = 32'h0;
    m0_wb_dat_r_o = 32'h0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_err_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_dat_r_o = 32'h0;
    m1_wb_ack_o   = 1'b0;
    m1_wb_err_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    case (state_q)
      OWN0: begin
        s_wb_cyc_o    = m0_wb_cyc_i;
        s_wb_stb_o    = m0_wb_cyc_i & m0_wb_stb_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_w_o  = m0_wb_dat_w_i;
        m0_wb_dat_r_o = s_wb_dat_r_i;
        m0_wb_ack_o   = s_wb_ack_i & ~s_wb_err_i;  // err wins a simultaneous ack
        m0_wb_err_o   = s_wb_err_i;
        m0_wb_stall_o = s_wb_stall_i;
      end
      OWN1: begin
        s_wb_cyc_o    = m1_wb_cyc_i;
        s_wb_stb_o    = m1_wb_cyc_i & m1_wb_stb_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_w_o  = m1_wb_dat_w_i;
        m1_wb_dat_r_o = s_wb_dat_r_i;
        m1_wb_ack_o   = s_wb_ack_i & ~s_wb_err_i;
        m1_wb_err_o   = s_wb_err_i;
        m1_wb_stall_o = s_wb_stall_i;
      end
      ABORT: begin
        // downstream cycle is dropped; any late slave ack is ignored
        if (grant_q[1]) begin
          m1_wb_err_o   = 1'b1;
          m1_wb_stall_o = 1'b0;
        end else begin
          m0_wb_err_o   = 1'b1;
          m0_wb_stall_o = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign o_grant   = grant_q;
  assign o_timeout = tmo_q;

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench: a round-robin instance (watchdog 8) and a fixed-priority
// instance (watchdog 255) share the same stimulus.
module tb_wb_arbiter_2to1;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m0_sel = 0, m1_sel = 0;
  logic [31:0] m0_adr = 0, m0_dw = 0, m1_adr = 0, m1_dw = 0;
  logic [31:0] s_dr = 0;
  logic        s_ack = 0, s_err = 0, s_stall = 0;

  logic [31:0] m0_dr, m1_dr, s_adr, s_dw;
  logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic        s_cyc, s_stb, s_we, tmo;
  logic [3:0]  s_sel;
  logic [1:0]  grant;

  logic [31:0] fx_m0_dr, fx_m1_dr, fx_s_adr, fx_s_dw;
  logic        fx_m0_ack, fx_m0_err, fx_m0_stall, fx_m1_ack, fx_m1_err, fx_m1_stall;
  logic        fx_s_cyc, fx_s_stb, fx_s_we, fx_tmo;
  logic [3:0]  fx_s_sel;
  logic [1:0]  fx_grant;

  wb_arbiter_2to1 #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(8)) u_rr (
    .i_clk(i_clk), .i_rst(i_rst),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we), .m0_wb_sel_i(m0_sel),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_w_i(m0_dw), .m0_wb_dat_r_o(m0_dr), .m0_wb_ack_o(m0_ack),
    .m0_wb_err_o(m0_err), .m0_wb_stall_o(m0_stall),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_sel_i(m1_sel),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_w_i(m1_dw), .m1_wb_dat_r_o(m1_dr), .m1_wb_ack_o(m1_ack),
    .m1_wb_err_o(m1_err), .m1_wb_stall_o(m1_stall),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_sel_o(s_sel),
    .s_wb_adr_o(s_adr), .s_wb_dat_w_o(s_dw), .s_wb_dat_r_i(s_dr), .s_wb_ack_i(s_ack),
    .s_wb_err_i(s_err), .s_wb_stall_i(s_stall),
    .o_grant(grant), .o_timeout(tmo)
  );

  wb_arbiter_2to1 #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(255)) u_fx (
    .i_clk(i_clk), .i_rst(i_rst),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we), .m0_wb_sel_i(m0_sel),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_w_i(m0_dw), .m0_wb_dat_r_o(fx_m0_dr), .m0_wb_ack_o(fx_m0_ack),
    .m0_wb_err_o(fx_m0_err), .m0_wb_stall_o(fx_m0_stall),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we), .m1_wb_sel_i(m1_sel),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_w_i(m1_dw), .m1_wb_dat_r_o(fx_m1_dr), .m1_wb_ack_o(fx_m1_ack),
    .m1_wb_err_o(fx_m1_err), .m1_wb_stall_o(fx_m1_stall),
    .s_wb_cyc_o(fx_s_cyc), .s_wb_stb_o(fx_s_stb), .s_wb_we_o(fx_s_we), .s_wb_sel_o(fx_s_sel),
    .s_wb_adr_o(fx_s_adr), .s_wb_dat_w_o(fx_s_dw), .s_wb_dat_r_i(s_dr), .s_wb_ack_i(s_ack),
    .s_wb_err_i(s_err), .s_wb_stall_i(s_stall),
    .o_grant(fx_grant), .o_timeout(fx_tmo)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drop_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_dw = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_dw = 0;
    s_ack = 0; s_err = 0; s_dr = 0;
  endtask

  // reset pulse placed between clock edges
  task automatic rst_pulse();
    drop_all();
    #2 i_rst = 1'b1;
    #2 i_rst = 1'b0;
  endtask

  initial begin
    // ---- reset state
    #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_tmo", tmo, 0);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_sadr", s_adr, 0);
    chk("rst_m0_stall", m0_stall, 1);
    chk("rst_m1_stall", m1_stall, 1);
    chk("rst_m0_ackerr", {m0_ack, m0_err}, 0);
    #9 i_rst = 1'b0;
    tick();

    // ---- 1: m0 read alone, slave acks on the third granted cycle
    m0_cyc = 1; m0_stb = 1; m0_sel = 4'hF; m0_adr = 32'h1000_0000;
    #1;
    chk("t1_latency_grant", grant, 2'b00);
    chk("t1_latency_scyc", s_cyc, 0);
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_scyc", s_cyc, 1);
    chk("t1_sadr", s_adr, 32'h1000_0000);
    chk("t1_m1_stall_a", m1_stall, 1);
    tick();
    tick();
    s_ack = 1; s_dr = 32'hDEAD_BEEF;
    #1;
    chk("t1_m0_ack", m0_ack, 1);
    chk("t1_m0_dat", m0_dr, 32'hDEAD_BEEF);
    chk("t1_m1_quiet", {m1_ack, m1_err, m1_dr}, 0);
    chk("t1_m1_stall_b", m1_stall, 1);
    tick();
    s_ack = 0; s_dr = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    chk("t1_scyc_drop", s_cyc, 0);
    tick();
    chk("t1_idle", grant, 2'b00);

    // ---- 2: simultaneous request from reset, round robin favours m1
    rst_pulse();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
    tick();
    chk("t2_grant_m1", grant, 2'b10);
    chk("t2_sadr", s_adr, 32'hB0);
    chk("t2_m0_stall", m0_stall, 1);
    s_ack = 1;
    #1;
    chk("t2_m1_ack", m1_ack, 1);
    chk("t2_m0_noack", m0_ack, 0);
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    chk("t2_gap_idle", grant, 2'b00);
    tick();
    chk("t2_grant_m0", grant, 2'b01);
    chk("t2_sadr_m0", s_adr, 32'hA0);
    m0_cyc = 0; m0_stb = 0;
    tick();

    // ---- 3: four contentions, both priority modes
    rst_pulse();
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      chk($sformatf("t3_rr_round%0d", r), grant, (r % 2 == 0) ? 2'b10 : 2'b01);
      chk($sformatf("t3_fx_round%0d", r), fx_grant, 2'b10);
      m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      tick();
      chk($sformatf("t3_idle%0d", r), grant, 2'b00);
    end

    // ---- 4: watchdog fires 8 cycles after grant
    rst_pulse();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
    tick();
    chk("t4_grant", grant, 2'b01);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("t4_wait%0d", k), {tmo, m0_err}, 2'b00);
    end
    tick();
    s_ack = 1;  // late ack during the abort
    #1;
    chk("t4_err", m0_err, 1);
    chk("t4_noack", m0_ack, 0);
    chk("t4_nostall", m0_stall, 0);
    chk("t4_tmo", tmo, 1);
    chk("t4_scyc", s_cyc, 0);
    chk("t4_m1_quiet", {m1_ack, m1_err}, 0);
    tick();
    chk("t4_tmo_pulse", tmo, 0);
    chk("t4_late_ack", {m0_ack, m0_err}, 0);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();

    // ---- 5: async reset during OWN1 with a pending strobe
    rst_pulse();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h77;
    tick();
    chk("t5_grant", grant, 2'b10);
    chk("t5_scyc", s_cyc, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("t5_rst_scyc", s_cyc, 0);
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_sadr", s_adr, 0);
    #3 i_rst = 1'b0;
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("t5_after_rst", grant, 2'b10);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick();

    // ---- 6: ack+err together on an m0 write; m0 wins after m1 owned last
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'b0011; m0_dw = 32'h0000_A5A5; m0_adr = 32'h80;
    m1_cyc = 1; m1_stb = 1;
    tick();
    chk("t6_grant", grant, 2'b01);
    chk("t6_swe", s_we, 1);
    chk("t6_ssel", s_sel, 4'b0011);
    chk("t6_sdw", s_dw, 32'h0000_A5A5);
    s_ack = 1; s_err = 1;
    #1;
    chk("t6_m0_err", m0_err, 1);
    chk("t6_m0_noack", m0_ack, 0);
    chk("t6_m1_quiet", {m1_ack, m1_err}, 0);
    tick();
    drop_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
